// File: rtl/chess_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chess_pkg
// Description : Shared types and constants for the board store and its
//               streaming transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package chess_pkg;

  localparam int PIECE_BITS  = 4;
  localparam int SQ_BITS     = 6;
  localparam int NUM_SQUARES = 64;

  typedef logic [PIECE_BITS-1:0] piece_t;
  typedef logic [SQ_BITS-1:0]    rankfile_t;

  localparam piece_t PIECE_EMPTY = '0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/board_regfile.sv
`default_nettype none
// ============================================================================
// Module      : board_regfile
// Description : 64-entry piece store, one write port, one asynchronous read
//               port and a whole-board clear. A write beats a clear.
// Revision    : 1.0 - initial release
// ============================================================================
module board_regfile
  import chess_pkg::*;
#(
  parameter int PIECE_W = 4,
  parameter int SQ_W    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [SQ_W-1:0]    wr_addr,
  input  logic [PIECE_W-1:0] wr_data,
  input  logic               clr,
  input  logic [SQ_W-1:0]    rd_addr,
  output logic [PIECE_W-1:0] rd_data
);

  localparam int c_depth = NUM_SQUARES;

  logic [PIECE_W-1:0] r_mem [c_depth];

  // Storage: clear everything first so a same-cycle write overrides its square
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_depth; i++) r_mem[i] <= PIECE_W'(PIECE_EMPTY);
    end else begin
      if (clr) begin
        for (int i = 0; i < c_depth; i++) r_mem[i] <= PIECE_W'(PIECE_EMPTY);
      end
      if (wr_en) r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/board_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : board_stream_tx
// Description : Holds a 64-square board and streams it out, square 0..63,
//               over a valid/ready interface with sop/eop framing. All
//               outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module board_stream_tx
  import chess_pkg::*;
#(
  parameter int PIECE_W = 4,
  parameter int SQ_W    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [SQ_W-1:0]    wr_rankfile,
  input  logic [PIECE_W-1:0] wr_piece,
  input  logic               clr,
  input  logic               start,
  output logic               busy,
  output logic               wr_err,
  output logic               out_pos_valid,
  output logic [PIECE_W-1:0] out_pos_data,
  output logic               out_pos_sop,
  output logic               out_pos_eop,
  input  logic               out_pos_ready
);

  localparam logic [SQ_W-1:0] c_last_sq = SQ_W'(NUM_SQUARES - 1);

  tx_state_t          r_state, w_state_nxt;
  logic [SQ_W-1:0]    r_sq, w_sq_nxt;
  logic               r_valid, w_valid_nxt;
  logic [PIECE_W-1:0] r_data, w_data_nxt;
  logic               r_sop, w_sop_nxt;
  logic               r_eop, w_eop_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_err, w_err_nxt;

  logic               w_idle;
  logic               w_store_wr;
  logic               w_store_clr;
  logic               w_reject;
  logic [SQ_W-1:0]    w_rd_addr;
  logic [PIECE_W-1:0] w_rd_data;
  logic [PIECE_W-1:0] w_first_piece;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_store_wr  = wr_en & w_idle;
  assign w_store_clr = clr & w_idle;
  assign w_reject    = (wr_en | clr) & ~w_idle;

  // In IDLE the read port looks at square 0; in SEND it prefetches the next square
  assign w_rd_addr = w_idle ? '0 : (r_sq + 1'b1);

  // Square 0 is sampled on the same edge the store is written, so forward
  // a concurrent write or clear into the first beat.
  assign w_first_piece = (wr_en && (wr_rankfile == '0)) ? wr_piece :
                         clr                             ? PIECE_W'(PIECE_EMPTY) :
                                                           w_rd_data;

  board_regfile #(
    .PIECE_W (PIECE_W),
    .SQ_W    (SQ_W)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_store_wr),
    .wr_addr (wr_rankfile),
    .wr_data (wr_piece),
    .clr     (w_store_clr),
    .rd_addr (w_rd_addr),
    .rd_data (w_rd_data)
  );

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sq    <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sq    <= w_sq_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_sop   <= w_sop_nxt;
      r_eop   <= w_eop_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_sq_nxt    = r_sq;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    w_sop_nxt   = r_sop;
    w_eop_nxt   = r_eop;
    w_err_nxt   = r_err | w_reject;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SEND;
          w_sq_nxt    = '0;
          w_valid_nxt = 1'b1;
          w_data_nxt  = w_first_piece;
          w_sop_nxt   = 1'b1;
          w_eop_nxt   = 1'b0;
          w_err_nxt   = w_reject;
        end
      end
      ST_SEND: begin
        if (r_valid && out_pos_ready) begin
          if (r_sq == c_last_sq) begin
            w_state_nxt = ST_IDLE;
            w_sq_nxt    = '0;
            w_valid_nxt = 1'b0;
            w_data_nxt  = '0;
            w_sop_nxt   = 1'b0;
            w_eop_nxt   = 1'b0;
          end else begin
            w_sq_nxt    = r_sq + 1'b1;
            w_data_nxt  = w_rd_data;
            w_sop_nxt   = 1'b0;
            w_eop_nxt   = ((r_sq + 1'b1) == c_last_sq);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == ST_SEND);
  end

  assign busy          = r_busy;
  assign wr_err        = r_err;
  assign out_pos_valid = r_valid;
  assign out_pos_data  = r_data;
  assign out_pos_sop   = r_sop;
  assign out_pos_eop   = r_eop;

endmodule
`default_nettype wire
